// File: rtl/distance_tracker_bcd.sv
// Remaining-distance tracker kept as a BCD digit chain, decremented by decade steps.
// Produces checkpoint and finish events for the HUD and game-flow controller.
module distance_tracker_bcd #(
   parameter int NUM_DIGITS       = 4,
   parameter int START_DIST       = 1000,
   parameter int CHECKPOINT_DIGIT = 2
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    load_en,
   input  logic                    start,
   input  logic                    pause,
   input  logic                    restart,
   input  logic                    step_pulse,
   input  logic                    player_move,
   input  logic [1:0]              speed_sel,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [1:0]              state,
   output logic                    dist_end,
   output logic                    checkpoint,
   output logic                    finish_pulse
);

   localparam int W = 4 * NUM_DIGITS;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      PAUSED   = 2'd2,
      FINISHED = 2'd3
   } state_t;

   function automatic logic [W-1:0] to_bcd(input int value);
      logic [W-1:0] r;
      int           rem;
      r   = '0;
      rem = value;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] START_BCD = to_bcd(START_DIST);

   state_t       state_q, state_d;
   logic [W-1:0] digits_d;
   logic         dist_end_d, checkpoint_d, finish_d;

   logic [W-1:0] stepped;
   logic         step_valid, upper_zero, cp_hit, borrow, step_go;
   int           dec;

   // Candidate result of a step: saturate to zero when the value is below the
   // step size, otherwise ripple a BCD borrow upward from the selected decade.
   always_comb begin
      dec        = int'(speed_sel) - 1;
      step_valid = (speed_sel != 2'd0) && (dec < NUM_DIGITS);
      upper_zero = 1'b1;
      borrow     = 1'b1;
      stepped    = digits;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= dec) begin
            if (digits[4*i +: 4] != 4'd0) upper_zero = 1'b0;
            if (borrow) begin
               if (digits[4*i +: 4] == 4'd0) begin
                  stepped[4*i +: 4] = 4'd9;
               end else begin
                  stepped[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                  borrow            = 1'b0;
               end
            end
         end
      end
      if (upper_zero) stepped = '0;
      cp_hit = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (i >= CHECKPOINT_DIGIT && stepped[4*i +: 4] != digits[4*i +: 4]) cp_hit = 1'b1;
      end
   end

   assign step_go = (state_q == RUN) && step_pulse && player_move && step_valid && !pause;

   always_comb begin
      state_d      = state_q;
      digits_d     = digits;
      dist_end_d   = dist_end;
      checkpoint_d = 1'b0;
      finish_d     = 1'b0;
      if (load_en) begin
         state_d    = IDLE;
         digits_d   = START_BCD;
         dist_end_d = 1'b0;
      end else begin
         case (state_q)
            IDLE:     if (start) state_d = RUN;
            RUN: begin
               if (pause) begin
                  state_d = PAUSED;
               end else if (step_go) begin
                  digits_d     = stepped;
                  checkpoint_d = cp_hit;
                  if (stepped == '0) begin
                     state_d    = FINISHED;
                     dist_end_d = 1'b1;
                     finish_d   = 1'b1;
                  end
               end
            end
            PAUSED:   if (!pause) state_d = RUN;
            FINISHED: begin
               if (restart) begin
                  state_d    = IDLE;
                  digits_d   = START_BCD;
                  dist_end_d = 1'b0;
               end
            end
            default:  state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= IDLE;
         digits       <= START_BCD;
         dist_end     <= 1'b0;
         checkpoint   <= 1'b0;
         finish_pulse <= 1'b0;
      end else begin
         state_q      <= state_d;
         digits       <= digits_d;
         dist_end     <= dist_end_d;
         checkpoint   <= checkpoint_d;
         finish_pulse <= finish_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_distance_tracker_bcd.sv
// Scoreboard bench for distance_tracker_bcd: default 4-digit instance plus a
// 6-digit instance (START_DIST 250000, checkpoint on thousands).
module tb_distance_tracker_bcd;

   localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_FIN = 2'd3;

   logic        clk = 1'b0;
   logic        resetN;
   logic        load_en, start, pause, restart, step_pulse, player_move;
   logic [1:0]  speed_sel;
   logic [15:0] digits;
   logic [1:0]  state;
   logic        dist_end, checkpoint, finish_pulse;

   logic        load6, start6, pause6, restart6, step6, move6;
   logic [1:0]  sel6;
   logic [23:0] digits6;
   logic [1:0]  state6;
   logic        dist_end6, checkpoint6, finish6;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   typedef struct {
      int          target;
      logic [15:0] dg;
      logic [1:0]  st;
      logic        de;
      logic        cp;
      logic        fp;
   } exp4_t;

   typedef struct {
      int          target;
      logic [23:0] dg;
      logic        cp;
   } exp6_t;

   exp4_t q4[$];
   exp6_t q6[$];
   exp4_t m4;
   exp6_t m6;

   distance_tracker_bcd dut (
      .clk(clk), .resetN(resetN), .load_en(load_en), .start(start), .pause(pause),
      .restart(restart), .step_pulse(step_pulse), .player_move(player_move),
      .speed_sel(speed_sel), .digits(digits), .state(state), .dist_end(dist_end),
      .checkpoint(checkpoint), .finish_pulse(finish_pulse)
   );

   distance_tracker_bcd #(.NUM_DIGITS(6), .START_DIST(250000), .CHECKPOINT_DIGIT(3)) dut6 (
      .clk(clk), .resetN(resetN), .load_en(load6), .start(start6), .pause(pause6),
      .restart(restart6), .step_pulse(step6), .player_move(move6),
      .speed_sel(sel6), .digits(digits6), .state(state6), .dist_end(dist_end6),
      .checkpoint(checkpoint6), .finish_pulse(finish6)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [23:0] to_bcd(input int value);
      logic [23:0] r;
      int          rem;
      r   = '0;
      rem = value;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one cycle of inputs on the 4-digit instance and queue its expected response.
   task automatic applyStimulus(input logic ld, input logic st, input logic pa, input logic rs,
                                input logic sp, input logic mv, input logic [1:0] sel,
                                input int exp_dist, input logic [1:0] exp_st,
                                input logic exp_de, input logic exp_cp, input logic exp_fp);
      exp4_t       e;
      logic [23:0] b;
      load_en = ld; start = st; pause = pa; restart = rs;
      step_pulse = sp; player_move = mv; speed_sel = sel;
      b        = to_bcd(exp_dist);
      e.target = cyc + 1;
      e.dg     = b[15:0];
      e.st     = exp_st;
      e.de     = exp_de;
      e.cp     = exp_cp;
      e.fp     = exp_fp;
      q4.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus6(input logic st, input logic sp, input int exp_dist, input logic exp_cp);
      exp6_t e;
      start6 = st; step6 = sp;
      e.target = cyc + 1;
      e.dg     = to_bcd(exp_dist);
      e.cp     = exp_cp;
      q6.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q4.size() > 0 && q4[0].target == cyc) begin
         m4 = q4.pop_front();
         checkOutput("digits",       32'(digits),       32'(m4.dg));
         checkOutput("state",        32'(state),        32'(m4.st));
         checkOutput("dist_end",     32'(dist_end),     32'(m4.de));
         checkOutput("checkpoint",   32'(checkpoint),   32'(m4.cp));
         checkOutput("finish_pulse", 32'(finish_pulse), 32'(m4.fp));
      end
      if (q6.size() > 0 && q6[0].target == cyc) begin
         m6 = q6.pop_front();
         checkOutput("digits6",     32'(digits6),     32'(m6.dg));
         checkOutput("checkpoint6", 32'(checkpoint6), 32'(m6.cp));
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      resetN = 1'b0;
      load_en = 0; start = 0; pause = 0; restart = 0; step_pulse = 0; player_move = 0; speed_sel = 0;
      load6 = 0; start6 = 0; pause6 = 0; restart6 = 0; step6 = 0; move6 = 1; sel6 = 2'd1;
      #12;
      checkOutput("reset_digits",   32'(digits),       32'h1000);
      checkOutput("reset_state",    32'(state),        32'(S_IDLE));
      checkOutput("reset_flags",    32'({dist_end, checkpoint, finish_pulse}), 32'd0);
      checkOutput("reset_digits6",  32'(digits6),      32'h250000);
      resetN = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(0,0,0,0,0,0,2'd0, 1000, S_IDLE, 0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1, 1000, S_IDLE, 0,0,0);
      applyStimulus(0,1,0,0,0,0,2'd0, 1000, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1,  999, S_RUN,  0,1,0);
      applyStimulus(0,0,0,0,1,1,2'd1,  998, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1,  997, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,0,2'd1,  997, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd0,  997, S_RUN,  0,0,0);
      for (int k = 0; k < 5; k++) applyStimulus(0,0,1,0,1,1,2'd1, 997, S_PAUSED, 0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1,  997, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1,  996, S_RUN,  0,0,0);
      for (int k = 1; k <= 8; k++) applyStimulus(0,0,0,0,1,1,2'd3, 996 - 100*k, S_RUN, 0,1,0);
      for (int k = 1; k <= 9; k++) applyStimulus(0,0,0,0,1,1,2'd2, 196 - 10*k,  S_RUN, 0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1,  105, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd3,    5, S_RUN,  0,1,0);
      applyStimulus(0,0,0,0,1,1,2'd3,    0, S_FIN,  1,0,1);
      applyStimulus(0,0,0,0,0,0,2'd0,    0, S_FIN,  1,0,0);
      applyStimulus(0,0,0,0,1,1,2'd1,    0, S_FIN,  1,0,0);
      applyStimulus(0,1,0,0,0,0,2'd0,    0, S_FIN,  1,0,0);
      applyStimulus(0,0,1,0,0,0,2'd0,    0, S_FIN,  1,0,0);
      applyStimulus(0,0,0,1,0,0,2'd0, 1000, S_IDLE, 0,0,0);
      applyStimulus(0,0,0,1,0,0,2'd0, 1000, S_IDLE, 0,0,0);
      applyStimulus(0,1,0,0,0,0,2'd0, 1000, S_RUN,  0,0,0);
      applyStimulus(0,0,0,0,1,1,2'd2,  990, S_RUN,  0,1,0);
      for (int k = 1; k <= 9; k++) applyStimulus(0,0,0,0,1,1,2'd3, 990 - 100*k, S_RUN, 0,1,0);
      applyStimulus(0,0,0,0,1,1,2'd3,    0, S_FIN,  1,0,1);
      applyStimulus(1,0,0,0,0,0,2'd0, 1000, S_IDLE, 0,0,0);
      applyStimulus(0,1,0,0,0,0,2'd0, 1000, S_RUN,  0,0,0);
      for (int k = 1; k <= 9; k++) applyStimulus(0,0,0,0,1,1,2'd3, 1000 - 100*k, S_RUN, 0,1,0);
      for (int k = 1; k <= 5; k++) applyStimulus(0,0,0,0,1,1,2'd2, 100 - 10*k, S_RUN, 0, (k == 1), 0);
      for (int k = 1; k <= 8; k++) applyStimulus(0,0,0,0,1,1,2'd1, 50 - k, S_RUN, 0,0,0);
      applyStimulus(1,0,0,0,1,1,2'd1, 1000, S_IDLE, 0,0,0);
      applyStimulus(0,0,0,0,0,0,2'd0, 1000, S_IDLE, 0,0,0);

      applyStimulus6(1, 0, 250000, 0);
      for (int k = 1; k <= 1000; k++) applyStimulus6(0, 1, 250000 - k, (k == 1));
      applyStimulus6(0, 0, 249000, 0);
      checkOutput("state6_run", 32'(state6), 32'(S_RUN));

      @(posedge clk);
      #1;
      checkOutput("queue4_drained", 32'(q4.size()), 32'd0);
      checkOutput("queue6_drained", 32'(q6.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
